button_debounce: RTL and testbench

Debounce controller for the mood-lighting push buttons. It synchronises one raw button input and confirms every change with an internal one-shot interval timer of 2^CNT_W cycles. It produces a clean level plus single-cycle press and release pulses for the mode and colour FSMs. It is the consumer of the interval-timer handshake: it issues the start, waits for terminal count, and aborts on bounce. It replaces stand-alone timer instances per button.

---
 rtl/button_debounce.sv | 130 +++++++++++++
 tb/tb_button_debounce.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Debounce controller: two-flop synchroniser, four-state confirm FSM with a
// one-shot 2^CNT_W interval, and an optional long-press pulse (LONG_PRESS_EN).
module button_debounce #(
  parameter int CNT_W   = 20,
  parameter bit ACT_LOW = 1'b1,
  parameter int HOLD_N  = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_lvl,
  output logic btn_p,
  output logic btn_r,
  output logic long_p,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, CONF_P, PRESSED, CONF_R} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2, btn_s, tc;
  logic             p_nxt, r_nxt, lvl_nxt, cnt_run;
  logic             lvl_q, p_q, r_q;

  if (HOLD_N < 1) begin : g_bad_hold
    $error("HOLD_N must be >= 1");
  end

  // Synchroniser idles at the inactive pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= ACT_LOW;
      s2 <= ACT_LOW;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  assign btn_s = s2 ^ ACT_LOW;
  assign tc    = &cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bounce is tested before terminal count so a drop on the last cycle aborts.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (btn_s) state_nxt = CONF_P;
      CONF_P:  if (!btn_s) state_nxt = IDLE;
               else if (tc) state_nxt = PRESSED;
      PRESSED: if (!btn_s) state_nxt = CONF_R;
      CONF_R:  if (btn_s) state_nxt = PRESSED;
               else if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    p_nxt   = (state == CONF_P) && btn_s && tc;
    r_nxt   = (state == CONF_R) && !btn_s && tc;
    lvl_nxt = (state_nxt == PRESSED) || (state_nxt == CONF_R);
`ifdef LONG_PRESS_EN
    cnt_run = (state == CONF_P) || (state == CONF_R) || (state == PRESSED);
`else
    cnt_run = (state == CONF_P) || (state == CONF_R);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (cnt_run)            cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 1'b0;
      p_q   <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      lvl_q <= lvl_nxt;
      p_q   <= p_nxt;
      r_q   <= r_nxt;
    end
  end

  assign btn_lvl = lvl_q;
  assign btn_p   = p_q;
  assign btn_r   = r_q;
  assign busy    = (state == CONF_P) || (state == CONF_R);

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_N + 1);

  logic [HW-1:0] hold;
  logic          fired, lp_q, hold_hit;

  // Count whole intervals only while staying in PRESSED; saturate at HOLD_N.
  assign hold_hit = (state == PRESSED) && (state_nxt == PRESSED) && tc &&
                    (hold != HW'(HOLD_N));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold  <= '0;
      fired <= 1'b0;
      lp_q  <= 1'b0;
    end else begin
      lp_q <= 1'b0;
      if (state_nxt != state) hold <= '0;
      else if (hold_hit)      hold <= hold + 1'b1;
      if (state == IDLE) begin
        fired <= 1'b0;
      end else if (hold_hit && (hold == HW'(HOLD_N - 1)) && !fired) begin
        lp_q  <= 1'b1;
        fired <= 1'b1;
      end
    end
  end

  assign long_p = lp_q;
`else
  assign long_p = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: an active-high and an active-low instance driven with
// complementary pins and checked against the same hand-derived timeline.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic lvl0, p0, r0, lp0, busy0;
  logic lvl1, p1, r1, lp1, busy1;
  logic [4:0] obs0, obs1, exp;
  int total = 0;
  int bad   = 0;

`ifdef LONG_PRESS_EN
  localparam bit LP_ON = 1'b1;
`else
  localparam bit LP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  button_debounce #(.CNT_W(4), .ACT_LOW(1'b0), .HOLD_N(3)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_lvl(lvl0), .btn_p(p0), .btn_r(r0), .long_p(lp0), .busy(busy0)
  );

  button_debounce #(.CNT_W(4), .ACT_LOW(1'b1), .HOLD_N(3)) dut1 (
    .clk(clk), .rst(rst), .btn_in(~btn),
    .btn_lvl(lvl1), .btn_p(p1), .btn_r(r1), .long_p(lp1), .busy(busy1)
  );

  // {btn_lvl, btn_p, btn_r, busy, long_p}
  assign obs0 = {lvl0, p0, r0, busy0, lp0};
  assign obs1 = {lvl1, p1, r1, busy1, lp1};

  // Each loop step: drive the value sampled at edge i, then look just after it.
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      rst = (i < 2);
      btn = 1'b0;
      @(posedge clk); #1;
      exp = 5'b0;
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL reset a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL reset a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i <= 20; i++) begin
      btn = 1'b1;
      @(posedge clk); #1;
      exp = {(i >= 18), (i == 18), 1'b0, (i >= 2 && i <= 17), 1'b0};
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL press a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL press a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
  endtask

  // Continues a hold whose confirmed press landed at edge s+18.
  task automatic test_long_hold(input int s, input int i0, input int i1);
    for (int i = i0; i <= i1; i++) begin
      btn = 1'b1;
      @(posedge clk); #1;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, (LP_ON && (i == s + 66))};
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL long a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL long a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
  endtask

  task automatic test_release_bounce();
    for (int i = 0; i <= 40; i++) begin
      btn = (i >= 4);
      @(posedge clk); #1;
      exp = {1'b1, 1'b0, 1'b0, (i >= 2 && i <= 5), 1'b0};
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL rel_bounce a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL rel_bounce a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
  endtask

  task automatic test_clean_release();
    for (int i = 0; i <= 20; i++) begin
      btn = 1'b0;
      @(posedge clk); #1;
      exp = {(i < 18), 1'b0, (i == 18), (i >= 2 && i <= 17), 1'b0};
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL release a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL release a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
  endtask

  // High 5, low 2, then held: final rising sample at edge 7, press at 25.
  task automatic test_press_bounce();
    for (int i = 0; i <= 27; i++) begin
      btn = (i < 5) || (i >= 7);
      @(posedge clk); #1;
      exp = {(i >= 25), (i == 25), 1'b0, ((i >= 2 && i <= 6) || (i >= 9 && i <= 24)), 1'b0};
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL press_bounce a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL press_bounce a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
  endtask

  // CONF_P entered at edge 2, cnt=9 after edge 11, rst sampled at edge 12.
  task automatic test_reset_mid_confirm();
    int j;
    for (int i = 0; i <= 33; i++) begin
      btn = 1'b1;
      rst = (i == 12);
      @(posedge clk); #1;
      j = i - 13;
      if (i < 12)       exp = {1'b0, 1'b0, 1'b0, (i >= 2), 1'b0};
      else if (i == 12) exp = 5'b0;
      else              exp = {(j >= 18), (j == 18), 1'b0, (j >= 2 && j <= 17), 1'b0};
      total += 2;
      if (obs0 !== exp) begin bad++; $display("FAIL rst_mid a0 i=%0d got=%b want=%b", i, obs0, exp); end
      if (obs1 !== exp) begin bad++; $display("FAIL rst_mid a1 i=%0d got=%b want=%b", i, obs1, exp); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    test_reset();
    test_clean_press();
    test_long_hold(0, 21, 100);
    test_release_bounce();
    test_clean_release();
    test_press_bounce();
    test_long_hold(7, 28, 100);
    test_clean_release();
    test_reset_mid_confirm();
    test_clean_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
